// File: rtl/mem_bist_pkg.sv
// ============================================================================
// Module      : mem_bist_pkg
// Description : Shared types and pattern helper for the memory BIST sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bit 0 set = read phase, bit 1 set = inverted pattern.
   typedef enum logic [1:0] {
      PH_W0 = 2'd0,
      PH_R0 = 2'd1,
      PH_W1 = 2'd2,
      PH_R1 = 2'd3
   } phase_t;

   localparam int c_PAT_W = 64;

   function automatic logic [c_PAT_W-1:0] pattern(input logic [c_PAT_W-1:0] seed,
                                                  input logic [c_PAT_W-1:0] addr,
                                                  input logic               inv);
      logic [c_PAT_W-1:0] p;
      p = seed ^ addr;
      return inv ? ~p : p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bist_chk.sv
// ============================================================================
// Module      : mem_bist_chk
// Description : Read-data compare, saturating error counter and optional
//               first-error log (enabled by MEM_BIST_ERR_LOG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bist_chk #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clr,
   input  logic                  i_chk_en,
   input  logic [WIDTH-1:0]      i_exp_data,
   input  logic [WIDTH-1:0]      i_rd_data,
   output logic [ERR_CNT_W-1:0]  o_err_cnt
`ifdef MEM_BIST_ERR_LOG_EN
   ,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_phase_r1,
   output logic                  o_first_err_vld,
   output logic [ADDR_WIDTH-1:0] o_first_err_addr,
   output logic [WIDTH-1:0]      o_first_err_data,
   output logic                  o_first_err_phase
`endif
);

   logic                 w_mismatch;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   assign w_mismatch = i_chk_en & (i_rd_data != i_exp_data);
   assign o_err_cnt  = r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if (i_clr) begin
         r_err_cnt <= '0;
      end else if (w_mismatch && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

`ifdef MEM_BIST_ERR_LOG_EN
   logic                  r_fe_vld;
   logic [ADDR_WIDTH-1:0] r_fe_addr;
   logic [WIDTH-1:0]      r_fe_data;
   logic                  r_fe_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fe_vld   <= 1'b0;
         r_fe_addr  <= '0;
         r_fe_data  <= '0;
         r_fe_phase <= 1'b0;
      end else if (i_clr) begin
         r_fe_vld   <= 1'b0;
         r_fe_addr  <= '0;
         r_fe_data  <= '0;
         r_fe_phase <= 1'b0;
      end else if (w_mismatch && !r_fe_vld) begin
         r_fe_vld   <= 1'b1;
         r_fe_addr  <= i_addr;
         r_fe_data  <= i_rd_data;
         r_fe_phase <= i_phase_r1;
      end
   end

   assign o_first_err_vld   = r_fe_vld;
   assign o_first_err_addr  = r_fe_addr;
   assign o_first_err_data  = r_fe_data;
   assign o_first_err_phase = r_fe_phase;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_bist_ctrl.sv
// ============================================================================
// Module      : mem_bist_ctrl
// Description : Four-phase march BIST sequencer (W0/R0/W1/R1) driving a
//               valid/ready memory port. MEM_BIST_ERR_LOG_EN adds first-error log.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bist_ctrl #(
   parameter  int WIDTH      = 16,
   parameter  int DEPTH      = 64,
   parameter  int ERR_CNT_W  = 8,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      seed_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [ERR_CNT_W-1:0]  err_cnt_o,
   output logic                  mem_valid_o,
   output logic                  mem_wr_rd_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WIDTH-1:0]      mem_wr_data_o,
   input  logic                  mem_ready_i,
   input  logic [WIDTH-1:0]      mem_rd_data_i
`ifdef MEM_BIST_ERR_LOG_EN
   ,
   output logic                  first_err_vld_o,
   output logic [ADDR_WIDTH-1:0] first_err_addr_o,
   output logic [WIDTH-1:0]      first_err_data_o,
   output logic                  first_err_phase_o
`endif
);

   import mem_bist_pkg::*;

   state_t                r_state;
   phase_t                r_phase;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WIDTH-1:0]      r_seed;
   logic                  r_valid;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_start;
   logic                  w_xfer;
   logic                  w_last_addr;
   logic                  w_is_write;
   logic [WIDTH-1:0]      w_pat;

   // Start is only honoured outside RUN, which also covers the final R1 cycle.
   assign w_start     = start_i & (r_state != ST_RUN);
   assign w_xfer      = r_valid & mem_ready_i;
   assign w_last_addr = (r_addr == ADDR_WIDTH'(DEPTH - 1));
   assign w_is_write  = ~r_phase[0];
   assign w_pat       = WIDTH'(pattern(c_PAT_W'(r_seed), c_PAT_W'(r_addr), r_phase[1]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_phase <= PH_W0;
         r_addr  <= '0;
         r_seed  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start) begin
                  r_state <= ST_RUN;
                  r_phase <= PH_W0;
                  r_addr  <= '0;
                  r_seed  <= seed_i;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (w_xfer) begin
                  if (w_last_addr) begin
                     r_addr  <= '0;
                     r_phase <= phase_t'(r_phase + 2'd1);
                     if (r_phase == PH_R1) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_addr <= r_addr + ADDR_WIDTH'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o        = r_busy;
   assign done_o        = r_done;
   assign pass_o        = r_done & (err_cnt_o == '0);
   assign mem_valid_o   = r_valid;
   assign mem_wr_rd_o   = r_valid & w_is_write;
   assign mem_addr_o    = r_addr;
   assign mem_wr_data_o = r_valid ? w_pat : '0;

   mem_bist_chk #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ERR_CNT_W  (ERR_CNT_W)
   ) u_chk (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_clr             (w_start),
      .i_chk_en          (w_xfer & ~w_is_write),
      .i_exp_data        (w_pat),
      .i_rd_data         (mem_rd_data_i),
      .o_err_cnt         (err_cnt_o)
`ifdef MEM_BIST_ERR_LOG_EN
      ,
      .i_addr            (r_addr),
      .i_phase_r1        (r_phase[1]),
      .o_first_err_vld   (first_err_vld_o),
      .o_first_err_addr  (first_err_addr_o),
      .o_first_err_data  (first_err_data_o),
      .o_first_err_phase (first_err_phase_o)
`endif
   );

endmodule

`default_nettype wire

// File: tb/tb_mem_bist_ctrl.sv
// ============================================================================
// Module      : tb_mem_bist_ctrl
// Description : Self-checking bench for mem_bist_ctrl with a behavioural memory
//               and march reference; also checks MEM_BIST_ERR_LOG_EN outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_bist_ctrl;

   localparam int WIDTH   = 16;
   localparam int DEPTH   = 64;
   localparam int ERR_W   = 8;
   localparam int AW      = 6;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_i;
   logic [WIDTH-1:0] seed_i;
   logic             busy_o, done_o, pass_o;
   logic [ERR_W-1:0] err_cnt_o;
   logic             mem_valid_o, mem_wr_rd_o;
   logic [AW-1:0]    mem_addr_o;
   logic [WIDTH-1:0] mem_wr_data_o;
   logic             mem_ready_i;
   logic [WIDTH-1:0] mem_rd_data_i;

   logic             s_start;
   logic             s_busy, s_done, s_pass;
   logic [3:0]       s_err;
   logic             s_valid, s_wr;
   logic [AW-1:0]    s_addr;
   logic [WIDTH-1:0] s_wdata;

`ifdef MEM_BIST_ERR_LOG_EN
   logic             fe_vld, fe_phase, s_fe_vld, s_fe_phase;
   logic [AW-1:0]    fe_addr, s_fe_addr;
   logic [WIDTH-1:0] fe_data, s_fe_data;
`endif

   always #5 clk = ~clk;

   mem_bist_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_CNT_W(ERR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .seed_i(seed_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
      .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
      .mem_wr_data_o(mem_wr_data_o), .mem_ready_i(mem_ready_i), .mem_rd_data_i(mem_rd_data_i)
`ifdef MEM_BIST_ERR_LOG_EN
      , .first_err_vld_o(fe_vld), .first_err_addr_o(fe_addr),
      .first_err_data_o(fe_data), .first_err_phase_o(fe_phase)
`endif
   );

   // Narrow-counter instance against a memory that always returns zero.
   mem_bist_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start_i(s_start), .seed_i(16'h1234),
      .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .err_cnt_o(s_err),
      .mem_valid_o(s_valid), .mem_wr_rd_o(s_wr), .mem_addr_o(s_addr),
      .mem_wr_data_o(s_wdata), .mem_ready_i(1'b1), .mem_rd_data_i(16'h0000)
`ifdef MEM_BIST_ERR_LOG_EN
      , .first_err_vld_o(s_fe_vld), .first_err_addr_o(s_fe_addr),
      .first_err_data_o(s_fe_data), .first_err_phase_o(s_fe_phase)
`endif
   );

   int               checks   = 0;
   int               failures = 0;
   logic [WIDTH-1:0] mem [DEPTH];
   int               g_cycles;
   int               g_err;
   logic [WIDTH-1:0] g_w0_a3, g_w1_a3;

   // Runs one march against the behavioural memory. mode: 0 ideal, 1 bit0 stuck-at-1
   // at address 10, 2 always reads zero. Returns early once abort_at transfers are done.
   task automatic run_bist(input logic [WIDTH-1:0] seed, input int mode, input bit stall,
                           input int abort_at, input int start_at);
      int               k, stall_cnt, ph, a;
      logic             exp_wr;
      logic [WIDTH-1:0] exp, rd;
      @(negedge clk);
      seed_i  = seed;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1 || done_o !== 1'b0 || err_cnt_o !== '0 || mem_valid_o !== 1'b1 ||
          mem_addr_o !== '0 || mem_wr_rd_o !== 1'b1) begin
         failures++;
         $display("FAIL start_accept: busy=%b done=%b err=%0d valid=%b addr=%0d wr=%b, required 1 0 0 1 0 1",
                  busy_o, done_o, err_cnt_o, mem_valid_o, mem_addr_o, mem_wr_rd_o);
      end
      k = 0; stall_cnt = 0; g_cycles = 1; g_err = 0;
      while (done_o !== 1'b1 && k != abort_at) begin
         start_i = (k == start_at);
         if (g_cycles > 2000) begin
            checks++; failures++;
            $display("FAIL timeout: transfers=%0d cycles=%0d, required done within 2000", k, g_cycles);
            break;
         end
         ph     = k / DEPTH;
         a      = k % DEPTH;
         exp_wr = (ph % 2 == 0);
         exp    = seed ^ WIDTH'(a);
         if (ph >= 2) exp = ~exp;
         rd = mem[a];
         if (mode == 1 && a == 10) rd[0] = 1'b1;
         if (mode == 2) rd = '0;
         mem_rd_data_i = rd;
         // The request for transfer k must be presented every cycle, stalled or not.
         checks++;
         if (mem_valid_o !== 1'b1 || mem_wr_rd_o !== exp_wr || mem_addr_o !== AW'(a) ||
             (exp_wr && mem_wr_data_o !== exp)) begin
            failures++;
            $display("FAIL request k=%0d: valid=%b wr=%b addr=%0d data=%h, required 1 %b %0d %h",
                     k, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o, exp_wr, a, exp);
         end
         if (stall && (k % 4) == 3 && stall_cnt < 2) begin
            mem_ready_i = 1'b0;
            stall_cnt++;
         end else begin
            mem_ready_i = 1'b1;
            if (k == 3)             g_w0_a3 = mem_wr_data_o;
            if (k == 2 * DEPTH + 3) g_w1_a3 = mem_wr_data_o;
            if (exp_wr) mem[a] = exp;
            else if (rd !== exp && g_err < ERR_MAX) g_err++;
            k++;
            stall_cnt = 0;
         end
         @(negedge clk);
         g_cycles++;
      end
      start_i     = 1'b0;
      mem_ready_i = 1'b0;
   endtask

   task automatic check_end(input string name, input int exp_cycles);
      checks++;
      if (g_cycles != exp_cycles || done_o !== 1'b1 || busy_o !== 1'b0 || mem_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL %s_timing: cycles=%0d done=%b busy=%b valid=%b, required %0d 1 0 0",
                  name, g_cycles, done_o, busy_o, mem_valid_o, exp_cycles);
      end
      checks++;
      if (err_cnt_o !== ERR_W'(g_err) || pass_o !== (g_err == 0)) begin
         failures++;
         $display("FAIL %s_result: err=%0d pass=%b, required err=%0d pass=%b",
                  name, err_cnt_o, pass_o, g_err, (g_err == 0));
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({busy_o, done_o, pass_o, err_cnt_o, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o} !== '0) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b pass=%b err=%0d valid=%b wr=%b addr=%0d data=%h, required all 0",
                  busy_o, done_o, pass_o, err_cnt_o, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o);
      end
   endtask

   task automatic test_clean;
      run_bist(16'hA5A5, 0, 1'b0, -1, -1);
      check_end("clean", 257);
      checks++;
      if (g_w0_a3 !== 16'hA5A6 || g_w1_a3 !== 16'h5A59 || pass_o !== 1'b1 || err_cnt_o !== '0) begin
         failures++;
         $display("FAIL clean_values: w0a3=%h w1a3=%h pass=%b err=%0d, required a5a6 5a59 1 0",
                  g_w0_a3, g_w1_a3, pass_o, err_cnt_o);
      end
   endtask

   task automatic test_stalls;
      run_bist(16'($urandom), 0, 1'b1, -1, -1);
      check_end("stalls", 257 + 2 * DEPTH);
   endtask

   task automatic test_stuck_bit;
      run_bist(16'hA5A5, 1, 1'b0, -1, -1);
      check_end("stuck", 257);
      checks++;
      if (err_cnt_o !== ERR_W'(1) || pass_o !== 1'b0) begin
         failures++;
         $display("FAIL stuck_count: err=%0d pass=%b, required 1 0", err_cnt_o, pass_o);
      end
`ifdef MEM_BIST_ERR_LOG_EN
      checks++;
      if (fe_vld !== 1'b1 || fe_addr !== AW'(10) || fe_data !== 16'h5A51 || fe_phase !== 1'b1) begin
         failures++;
         $display("FAIL first_err: vld=%b addr=%0d data=%h phase=%b, required 1 10 5a51 1",
                  fe_vld, fe_addr, fe_data, fe_phase);
      end
`endif
   endtask

   task automatic test_random_runs;
      for (int i = 0; i < 4; i++) begin
         run_bist(16'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1, -1);
         checks++;
         if (done_o !== 1'b1 || err_cnt_o !== ERR_W'(g_err) || pass_o !== (g_err == 0)) begin
            failures++;
            $display("FAIL random_run%0d: done=%b err=%0d pass=%b, required 1 %0d %b",
                     i, done_o, err_cnt_o, pass_o, g_err, (g_err == 0));
         end
      end
   endtask

   task automatic test_start_ignored;
      run_bist(16'h0F0F, 0, 1'b0, -1, 100);
      check_end("start_midrun", 257);
      run_bist(16'h3C3C, 0, 1'b0, -1, 4 * DEPTH - 1);
      check_end("start_final", 257);
      repeat (2) @(negedge clk);
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || mem_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL done_hold: done=%b busy=%b valid=%b, required 1 0 0", done_o, busy_o, mem_valid_o);
      end
   endtask

   task automatic test_saturation;
      int cyc;
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      cyc = 1;
      while (s_done !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (s_done !== 1'b1 || cyc != 257 || s_err !== 4'hF || s_pass !== 1'b0 || s_busy !== 1'b0) begin
         failures++;
         $display("FAIL saturation: done=%b cycles=%0d err=%0d pass=%b busy=%b, required 1 257 15 0 0",
                  s_done, cyc, s_err, s_pass, s_busy);
      end
   endtask

   task automatic test_reset_midrun;
      run_bist(16'h1357, 0, 1'b0, DEPTH + 16, -1);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || err_cnt_o !== '0 ||
          mem_addr_o !== '0 || mem_wr_data_o !== '0) begin
         failures++;
         $display("FAIL reset_midrun: valid=%b busy=%b done=%b err=%0d addr=%0d data=%h, required all 0",
                  mem_valid_o, busy_o, done_o, err_cnt_o, mem_addr_o, mem_wr_data_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_bist(16'h2468, 0, 1'b0, -1, -1);
      check_end("after_reset", 257);
   endtask

   initial begin
      rst_n         = 1'b0;
      start_i       = 1'b0;
      s_start       = 1'b0;
      seed_i        = '0;
      mem_ready_i   = 1'b0;
      mem_rd_data_i = '0;
      #1;
      test_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_clean();
      test_stalls();
      test_stuck_bit();
      test_clean();
      test_random_runs();
      test_start_ignored();
      test_saturation();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Built-in self-test sequencer that sits directly upstream of the `memory` block and drives its valid/ready request port in place of the functional master. On a start pulse it runs a four-phase march:

- write a pattern to every location;
- read it back and compare;
- write the inverted pattern;
- read it back and compare.

It reports done, pass/fail and a saturating error count.

## Interface
- `WIDTH`, 16, memory data width; must be >= ADDR_WIDTH.
- `DEPTH`, 64, number of memory locations; ADDR_WIDTH = $clog2(DEPTH).
- `ERR_CNT_W`, 8, width of the error counter.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  single-cycle start request; ignored while busy_o=1.
- `seed_i`  in  WIDTH  pattern seed; sampled when start is accepted.
- `busy_o`  out  1  high from start acceptance until the last R1 handshake.
- `done_o`  out  1  high after a run completes; held until the next accepted start.
- `pass_o`  out  1  done_o & (err_cnt_o==0).
- `err_cnt_o`  out  ERR_CNT_W  number of mismatching reads in the current or last run; saturates at all-ones.
- `mem_valid_o`  out  1  request valid to memory.
- `mem_wr_rd_o`  out  1  1=write, 0=read.
- `mem_addr_o`  out  ADDR_WIDTH  request address.
- `mem_wr_data_o`  out  WIDTH  write data.
- `mem_ready_i`  in  1  memory accepts or completes the current request.
- `mem_rd_data_i`  in  WIDTH  read data; valid in the handshake cycle of a read.

## Operation
- **Reset values:** all outputs are 0; state=IDLE, phase=W0, addr=0, err_cnt=0, seed register=0.
- **Pattern:** P(a) = seed ^ zero-extend(a, WIDTH).
- **Phase order:** all phases walk address 0 to DEPTH-1 ascending.
  - W0 writes P(a).
  - R0 reads and expects P(a).
  - W1 writes ~P(a).
  - R1 reads and expects ~P(a).
- **Handshake:** a transfer occurs at a rising edge where mem_valid_o & mem_ready_i.
  - While mem_valid_o=1 and no transfer has occurred, addr, wr_rd and data are held stable.
  - mem_valid_o never drops before its transfer.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on start_i: latch seed_i, clear err_cnt, phase=W0, addr=0.
  - RUN keeps mem_valid_o=1 continuously, so back-to-back transfers are possible.
  - On each transfer in RUN: if it is a read and mem_rd_data_i != expected, err_cnt increments, saturating.
  - On each transfer in RUN, addr increments; at addr=DEPTH-1, addr wraps to 0 and phase advances.
  - A transfer at addr=DEPTH-1 in R1 → DONE.
  - DONE → RUN on start_i, with the same initialisation as from IDLE.
- **Outputs by state:** busy_o=1 only in RUN; done_o=1 only in DONE.
- **Start handling:** start_i in RUN is ignored. start_i in the same cycle as the final R1 transfer is ignored.
- **Error counting:** the comparison uses the sampled data of the handshake cycle only. Write transfers never affect err_cnt.
- **Reset mid-run:** asynchronous assertion forces the reset values immediately, including mem_valid_o=0. There is no resume; a new start is required.

## Timing
- Start accepted at edge N; mem_valid_o=1 from cycle N+1, with addr 0 of W0 presented.
- With mem_ready_i held high: one transfer per cycle, so 4*DEPTH cycles from first valid to last transfer.
- busy_o falls and done_o rises in the cycle after the final R1 transfer. pass_o and err_cnt_o are final in that same cycle.
- Each ready stall cycle adds exactly one cycle; there is no internal bubble between phases.

## Configuration
- `MEM_BIST_ERR_LOG_EN` defined: adds the following outputs.
  - `first_err_vld_o` (1), `first_err_addr_o` (ADDR_WIDTH), `first_err_data_o` (WIDTH, the data read) and `first_err_phase_o` (1, 0=R0, 1=R1).
  - These capture the first mismatch of a run and are cleared on start acceptance and on reset.
- Undefined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Package `mem_bist_pkg`:
  - state enum (ST_IDLE, ST_RUN, ST_DONE);
  - phase enum (PH_W0, PH_R0, PH_W1, PH_R1);
  - pattern function pattern(seed, addr, inv).
- Sub-module `mem_bist_chk`: compare, saturating error counter and the optional first-error log. The top holds the FSM and the address/phase counters.

## Test plan
- **Clean run:** WIDTH=16, DEPTH=64, seed=16'hA5A5, ideal memory with ready always high.
  - W0 addr 3 writes 16'hA5A6; W1 addr 3 writes 16'h5A59.
  - done_o rises 257 cycles after start acceptance (256 transfers + 1); pass_o=1, err_cnt_o=0.
- **Stalls:** ready low for 2 cycles before every 4th request.
  - addr, wr_rd and data are held stable while valid is high without ready.
  - Total time = 257 + 2*64 cycles; pass_o=1.
- **Stuck bit:** memory returns bit 0 forced to 1 at addr 10.
  - The expected value there is A5AF in R0 (bit 0 already 1, no error) and 5A50 in R1, so exactly one error: err_cnt_o=1, pass_o=0.
  - With MEM_BIST_ERR_LOG_EN: first_err_addr_o=10, first_err_data_o=16'h5A51, first_err_phase_o=1.
- **Saturation:** ERR_CNT_W=4, memory always returns 0 → err_cnt_o=15, pass_o=0.
- **Control corner cases:**
  - start_i pulsed mid-run is ignored; the run completes normally.
  - A restart from DONE clears err_cnt_o and done_o.
- **Reset mid-run:** rst_n asserted during R0 → mem_valid_o=0 without waiting for a clock edge; all outputs return to 0; the next start runs a full clean pass.
